// File: rtl/load_store_unit.sv
// Memory-access stage: single-outstanding req/ack data port, load extension, store strobes.
// Optional build macro MISALIGN_TRAP_EN turns misaligned H/W accesses into error responses.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  a_q;
  logic [7:0]  cnt;
  logic        req_bad;
  logic [3:0]  strb;
  logic [31:0] wdata_rep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        timeout_hit;

  assign req_ready   = (state == IDLE);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

  always_comb begin
    req_bad = 1'b0;
    if (req_we) begin
      req_bad = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 || req_funct3 == 3'b010);
    end else begin
      req_bad = (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
    end
`ifdef MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_bad = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      req_bad = 1'b1;
`endif
  end

  always_comb begin
    strb      = '0;
    wdata_rep = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          strb      = 4'b0001 << req_addr[1:0];
          wdata_rep = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          strb      = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{req_wdata[15:0]}};
        end
        default: begin
          strb      = 4'b1111;
          wdata_rep = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel = mem_rdata[{a_q, 3'b000} +: 8];
    half_sel = a_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      a_q        <= '0;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            a_q      <= req_addr[1:0];
            cnt      <= '0;
            if (req_bad) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wstrb <= strb;
              mem_wdata <= wdata_rep;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          // an ack in the timeout cycle takes priority over the timeout
          if (mem_ack) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_wstrb  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_data  <= we_q ? '0 : load_ext;
          end else if (timeout_hit) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_wstrb  <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_data  <= '0;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases plus random transactions
// against an arithmetic reference model (timeout set to 4 cycles).
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  int tests = 0;
  int fails = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input bit we, input int f3);
    if (we) return f3 <= 2;
    return f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5;
  endfunction

  function automatic bit ref_misaligned(input int f3, input longint addr);
`ifdef MISALIGN_TRAP_EN
    if (f3 % 4 == 1) return (addr % 2) != 0;
    if (f3 % 4 == 2) return (addr % 4) != 0;
`endif
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input longint addr, input longint rd);
    longint v;
    if (f3 % 4 == 0) begin
      v = (rd >> (8 * (addr % 4))) % 256;
      if (f3 == 0 && v >= 128) v = v - 256;
    end else if (f3 % 4 == 1) begin
      v = (rd >> (16 * ((addr / 2) % 2))) % 65536;
      if (f3 == 1 && v >= 32768) v = v - 65536;
    end else begin
      v = rd;
    end
    return 32'(v);
  endfunction

  function automatic logic [3:0] ref_strb(input int f3, input longint addr);
    if (f3 == 0) return 4'(1 << (addr % 4));
    if (f3 == 1) return 4'(3 << (2 * ((addr / 2) % 2)));
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input longint wd);
    if (f3 == 0) return 32'((wd % 256) * 32'h01010101);
    if (f3 == 1) return 32'((wd % 65536) * 32'h00010001);
    return 32'(wd);
  endfunction

  // ack_at: REQ cycle (1-based) in which mem_ack is raised; > TO means never
  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                     output logic [31:0] got_data, output logic got_err);
    bit acked;
    int req_cycles;
    chk("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (!ref_legal(we, int'(f3)) || ref_misaligned(int'(f3), longint'(addr))) begin
      chk("bad_no_mem_req", mem_req, 0);
      chk("bad_resp_valid", resp_valid, 1);
      chk("bad_resp_err", resp_err, 1);
      chk("bad_resp_data", resp_data, 0);
    end else begin
      acked = 0;
      req_cycles = 0;
      for (int k = 1; k <= TO; k++) begin
        req_cycles++;
        chk("req_mem_req", mem_req, 1);
        chk("req_mem_we", mem_we, 32'(we));
        chk("req_mem_addr", mem_addr, {addr[31:2], 2'b00});
        chk("req_mem_wstrb", mem_wstrb, we ? ref_strb(int'(f3), longint'(addr)) : 4'd0);
        if (we) chk("req_mem_wdata", mem_wdata, ref_wdata(int'(f3), longint'(wd)));
        chk("req_no_resp", resp_valid, 0);
        chk("req_not_ready", req_ready, 0);
        if (k == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rd;
        end
        @(posedge clk); @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (k == ack_at) begin
          acked = 1;
          break;
        end
      end
      chk("resp_mem_req_low", mem_req, 0);
      chk("resp_valid", resp_valid, 1);
      chk("resp_err", resp_err, acked ? 0 : 1);
      chk("resp_data", resp_data, (acked && !we) ? ref_load(int'(f3), longint'(addr), longint'(rd)) : 32'd0);
      if (!acked) chk("timeout_len", req_cycles, TO);
    end
    got_data = resp_data;
    got_err  = resp_err;
    // a stray ack while not in REQ must have no effect
    mem_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    chk("after_resp_valid", resp_valid, 0);
    chk("after_ready", req_ready, 1);
    chk("after_mem_req", mem_req, 0);
  endtask

  logic [31:0] d;
  logic        e;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_req_ready", req_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    txn(0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1, d, e);
    chk("plan_lb_data", d, 32'hFFFF_FF80);
    chk("plan_lb_err", e, 0);
    txn(0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_0001, 2, d, e);
    chk("plan_lhu_data", d, 32'h0000_BEEF);
    txn(0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_0001, 1, d, e);
    chk("plan_lh_data", d, 32'hFFFF_BEEF);
    txn(1, 3'b000, 32'h0000_3001, 32'h1234_56A5, 32'h0, 1, d, e);
    chk("plan_sb_data", d, 32'h0);
    txn(0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_2222, TO + 1, d, e);
    chk("plan_timeout_err", e, 1);
    txn(0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_2222, TO, d, e);
    chk("plan_ack_at_timeout_err", e, 0);
    chk("plan_ack_at_timeout_data", d, 32'h1111_2222);
    txn(0, 3'b010, 32'h0000_4002, 32'h0, 32'hCAFE_F00D, 1, d, e);
`ifdef MISALIGN_TRAP_EN
    chk("plan_lw_mis_err", e, 1);
`else
    chk("plan_lw_mis_data", d, 32'hCAFE_F00D);
`endif
    txn(0, 3'b011, 32'h0000_6000, 32'h0, 32'h0, 1, d, e);
    chk("plan_illegal_ld", e, 1);
    txn(1, 3'b100, 32'h0000_6000, 32'h0, 32'h0, 1, d, e);
    chk("plan_illegal_st", e, 1);

    for (int i = 0; i < 60; i++) begin
      txn(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, $urandom,
          int'($urandom_range(1, TO + 1)), d, e);
    end

    // reset while a load is waiting for its ack
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_7000;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_in_req", mem_req, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_ready", req_ready, 1);
    chk("rstmid_no_resp", resp_valid, 0);
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    chk("rstmid_late_ack_no_resp", resp_valid, 0);
    chk("rstmid_late_ack_mem_req", mem_req, 0);
    chk("rstmid_late_ack_ready", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
